scratch_pad_arbiter: RTL and testbench

Arbiter and sequencer for the single-ported scratch-pad data memory (separate read/write address buses, 4 byte write enables, 1-cycle synchronous read). Shares the memory between the core data port (requester 0) and the boot/debug loader (requester 1). After reset it runs in a LOAD phase, where only the loader has access. It then switches to RUN, where the core has fixed priority and a starvation counter guarantees the loader forward progress. Sits between the pipeline's memory stage / loader and the scratch-pad memory instance.

---
 rtl/scratch_pad_pkg.sv | 21 ++
 rtl/scratch_pad_arbiter_starvation_counter.sv | 30 +++
 rtl/scratch_pad_arbiter.sv | 123 ++++++++++++
 tb/tb_scratch_pad_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/scratch_pad_pkg.sv
// Shared types and constants for the scratch-pad memory arbiter.
// Requesters are indexed CORE/LOADER throughout the datapath.
package scratch_pad_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } phase_e;

  localparam int CORE    = 0;
  localparam int LOADER  = 1;
  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

endpackage

// File: rtl/scratch_pad_arbiter_starvation_counter.sv
// Saturating wait counter: counts consecutive loader denials and flags
// the terminal count that forces a loader grant.
module starvation_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_inc,
  input  logic       i_clr,
  output logic [3:0] o_count,
  output logic       o_tc
);
  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [3:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= 4'd0;
    end else if (i_clr) begin
      r_count <= 4'd0;
    end else if (i_inc && (r_count != MAX_CNT)) begin
      r_count <= r_count + 4'd1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == MAX_CNT);

endmodule

// File: rtl/scratch_pad_arbiter.sv
// Arbiter/sequencer sharing the single-ported scratch-pad between the core
// (fixed priority in RUN) and the boot/debug loader (exclusive in LOAD).
module scratch_pad_arbiter
  import scratch_pad_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 io_loadDone,
  input  logic [NUM_REQ-1:0]                   io_req_valid,
  output logic [NUM_REQ-1:0]                   io_req_ready,
  input  logic [NUM_REQ-1:0]                   io_req_write,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   io_req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   io_req_wdata,
  input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0] io_req_wstrb,
  output logic [NUM_REQ-1:0]                   io_resp_valid,
  output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   io_resp_rdata,
  output logic [ADDR_WIDTH-1:0]                io_mem_rdAddress,
  input  logic [DATA_WIDTH-1:0]                io_mem_rdData,
  output logic [ADDR_WIDTH-1:0]                io_mem_wrAddress,
  output logic [DATA_WIDTH-1:0]                io_mem_wrData,
  output logic                                 io_mem_wrEnable_0,
  output logic                                 io_mem_wrEnable_1,
  output logic                                 io_mem_wrEnable_2,
  output logic                                 io_mem_wrEnable_3,
  output logic                                 io_phaseRun
);
  // Handshake: a request is accepted in any cycle where valid & ready are
  // both high. Ready may depend combinationally on the core's valid; a
  // requester must never make its valid depend on ready.

  phase_e                  r_state;
  phase_e                  w_next_state;
  logic                    r_resp_pending;
  logic                    r_resp_owner;
  logic [ADDR_WIDTH-1:0]   r_last_rd_addr;

  logic                    w_run;
  logic                    w_force;
  logic [NUM_REQ-1:0]      w_gnt;
  logic                    w_sel;
  logic                    w_any;
  logic                    w_rd_gnt;
  logic                    w_wr_gnt;
  logic [DATA_WIDTH/8-1:0] w_we;
  logic                    w_cnt_inc;
  logic                    w_cnt_clr;
  logic [3:0]              w_wait_cnt;

  starvation_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_cnt_inc),
    .i_clr   (w_cnt_clr),
    .o_count (w_wait_cnt),
    .o_tc    (w_force)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  // RUN is terminal; a late loadDone pulse has no effect.
  always_comb begin
    w_next_state = r_state;
    if ((r_state == LOAD) && io_loadDone) begin
      w_next_state = RUN;
    end
  end

  always_comb begin
    w_run        = (r_state == RUN);
    io_req_ready = 2'b10;
    if (w_run) begin
      io_req_ready[CORE]   = !w_force;
      io_req_ready[LOADER] = !io_req_valid[CORE] || w_force;
    end
    w_gnt     = io_req_valid & io_req_ready;
    w_sel     = w_gnt[LOADER];
    w_any     = |w_gnt;
    w_rd_gnt  = w_any && !io_req_write[w_sel];
    w_wr_gnt  = w_any && io_req_write[w_sel];
    w_cnt_inc = w_run && io_req_valid[LOADER] && !w_gnt[LOADER];
    w_cnt_clr = !w_run || !io_req_valid[LOADER] || w_gnt[LOADER];
    w_we      = w_wr_gnt ? io_req_wstrb[w_sel] : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_resp_pending <= 1'b0;
      r_resp_owner   <= 1'b0;
      r_last_rd_addr <= '0;
    end else begin
      r_resp_pending <= w_rd_gnt;
      if (w_rd_gnt) begin
        r_resp_owner   <= w_sel;
        r_last_rd_addr <= io_req_addr[w_sel];
      end
    end
  end

  assign io_mem_rdAddress  = w_rd_gnt ? io_req_addr[w_sel] : r_last_rd_addr;
  assign io_mem_wrAddress  = io_req_addr[w_sel];
  assign io_mem_wrData     = io_req_wdata[w_sel];
  assign io_mem_wrEnable_0 = w_we[0];
  assign io_mem_wrEnable_1 = w_we[1];
  assign io_mem_wrEnable_2 = w_we[2];
  assign io_mem_wrEnable_3 = w_we[3];
  assign io_phaseRun       = w_run;

  assign io_resp_valid[CORE]   = r_resp_pending && (r_resp_owner == 1'b0);
  assign io_resp_valid[LOADER] = r_resp_pending && (r_resp_owner == 1'b1);
  assign io_resp_rdata[CORE]   = io_mem_rdData;
  assign io_resp_rdata[LOADER] = io_mem_rdData;

endmodule

// File: tb/tb_scratch_pad_arbiter.sv
// Table-driven bench for scratch_pad_arbiter with a behavioural scratch-pad
// memory and an in-order read-response scoreboard.
module tb_scratch_pad_arbiter;
  import scratch_pad_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              io_loadDone;
  logic [1:0]        io_req_valid;
  logic [1:0]        io_req_ready;
  logic [1:0]        io_req_write;
  logic [1:0][31:0]  io_req_addr;
  logic [1:0][31:0]  io_req_wdata;
  logic [1:0][3:0]   io_req_wstrb;
  logic [1:0]        io_resp_valid;
  logic [1:0][31:0]  io_resp_rdata;
  logic [31:0]       io_mem_rdAddress;
  logic [31:0]       io_mem_rdData;
  logic [31:0]       io_mem_wrAddress;
  logic [31:0]       io_mem_wrData;
  logic              io_mem_wrEnable_0;
  logic              io_mem_wrEnable_1;
  logic              io_mem_wrEnable_2;
  logic              io_mem_wrEnable_3;
  logic              io_phaseRun;

  // clock / reset
  always #5 clock = ~clock;

  scratch_pad_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .io_loadDone       (io_loadDone),
    .io_req_valid      (io_req_valid),
    .io_req_ready      (io_req_ready),
    .io_req_write      (io_req_write),
    .io_req_addr       (io_req_addr),
    .io_req_wdata      (io_req_wdata),
    .io_req_wstrb      (io_req_wstrb),
    .io_resp_valid     (io_resp_valid),
    .io_resp_rdata     (io_resp_rdata),
    .io_mem_rdAddress  (io_mem_rdAddress),
    .io_mem_rdData     (io_mem_rdData),
    .io_mem_wrAddress  (io_mem_wrAddress),
    .io_mem_wrData     (io_mem_wrData),
    .io_mem_wrEnable_0 (io_mem_wrEnable_0),
    .io_mem_wrEnable_1 (io_mem_wrEnable_1),
    .io_mem_wrEnable_2 (io_mem_wrEnable_2),
    .io_mem_wrEnable_3 (io_mem_wrEnable_3),
    .io_phaseRun       (io_phaseRun)
  );

  // behavioural single-port memory, 1-cycle synchronous read
  logic [31:0] mem [64];
  logic [31:0] mem_rd_q;
  logic [3:0]  w_we;
  assign w_we = {io_mem_wrEnable_3, io_mem_wrEnable_2, io_mem_wrEnable_1, io_mem_wrEnable_0};
  assign io_mem_rdData = mem_rd_q;

  always @(posedge clock) begin
    for (int k = 0; k < 4; k++) begin
      if (w_we[k]) mem[io_mem_wrAddress[7:2]][8*k +: 8] <= io_mem_wrData[8*k +: 8];
    end
    mem_rd_q <= mem[io_mem_rdAddress[7:2]];
  end

  function automatic logic [31:0] preload(int i);
    return {8'hA0 + 8'(i), 8'hB1, 8'hC2, 8'hD0 + 8'(i)};
  endfunction

  // scoreboard state
  logic [31:0] ref_mem [64];
  logic [32:0] exp_q [$];
  logic [31:0] exp_last_rd;
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        ld;
    logic [1:0]  v;
    logic [1:0]  w;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [3:0]  s1;
    logic [1:0]  e_rdy;   // {loader, core}
    logic [1:0]  e_gnt;   // 0 none, 1 core, 2 loader
    logic        e_run;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_resp();
    logic [32:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("resp_valid", 64'(io_resp_valid), e[32] ? 64'h2 : 64'h1);
      check("resp_rdata", 64'(io_resp_rdata[e[32]]), 64'(e[31:0]));
    end else begin
      check("resp_idle", 64'(io_resp_valid), 64'h0);
    end
  endtask

  // driver: drive one cycle, check at negedge, return #1 after next posedge
  task automatic apply(input vec_t t);
    int          g;
    logic [31:0] a;
    io_loadDone     = t.ld;
    io_req_valid    = t.v;
    io_req_write    = t.w;
    io_req_addr[0]  = t.a0;
    io_req_addr[1]  = t.a1;
    io_req_wdata[0] = 32'h0BAD0BAD;
    io_req_wdata[1] = t.d1;
    io_req_wstrb[0] = 4'hF;
    io_req_wstrb[1] = t.s1;
    @(negedge clock);
    check_resp();
    check("ready", 64'(io_req_ready), 64'(t.e_rdy));
    check("phase_run", 64'(io_phaseRun), 64'(t.e_run));
    if (t.e_gnt != 2'd0) begin
      g = (t.e_gnt == 2'd2) ? 1 : 0;
      a = (g == 1) ? t.a1 : t.a0;
      if (t.w[g]) begin
        check("wr_enable", 64'(w_we), (g == 1) ? 64'(t.s1) : 64'hF);
        check("wr_address", 64'(io_mem_wrAddress), 64'(a));
        check("wr_data", 64'(io_mem_wrData), (g == 1) ? 64'(t.d1) : 64'h0BAD0BAD);
        for (int k = 0; k < 4; k++) begin
          if (((g == 1) ? t.s1[k] : 1'b1))
            ref_mem[a[7:2]][8*k +: 8] = (g == 1) ? t.d1[8*k +: 8] : 8'hAD;
        end
      end else begin
        check("rd_address", 64'(io_mem_rdAddress), 64'(a));
        check("rd_no_we", 64'(w_we), 64'h0);
        exp_q.push_back({g[0], ref_mem[a[7:2]]});
        exp_last_rd = a;
      end
    end else begin
      check("idle_rd_address", 64'(io_mem_rdAddress), 64'(exp_last_rd));
      check("idle_no_we", 64'(w_we), 64'h0);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t rv;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = preload(i);
      ref_mem[i] = preload(i);
    end
    exp_last_rd  = 32'h0;
    reset        = 1'b0;
    io_loadDone  = 1'b0;
    io_req_valid = 2'b00;
    io_req_write = 2'b00;
    io_req_addr  = '0;
    io_req_wdata = '0;
    io_req_wstrb = '0;

    //            ld    v      w      a0      a1      d1            s1    rdy    gnt   run
    tbl[0]  = '{1'b0, 2'b11, 2'b10, 32'h00, 32'h10, 32'hDEADBEEF, 4'hF, 2'b10, 2'd2, 1'b0};
    tbl[1]  = '{1'b0, 2'b11, 2'b00, 32'h04, 32'h10, 32'h0,        4'h0, 2'b10, 2'd2, 1'b0};
    tbl[2]  = '{1'b1, 2'b01, 2'b00, 32'h10, 32'h00, 32'h0,        4'h0, 2'b10, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 2'b01, 2'b00, 32'h10, 32'h00, 32'h0,        4'h0, 2'b01, 2'd1, 1'b1};
    tbl[4]  = '{1'b1, 2'b00, 2'b00, 32'h00, 32'h00, 32'h0,        4'h0, 2'b11, 2'd0, 1'b1};
    tbl[5]  = '{1'b0, 2'b11, 2'b00, 32'h00, 32'h04, 32'h0,        4'h0, 2'b01, 2'd1, 1'b1};
    tbl[6]  = '{1'b0, 2'b11, 2'b00, 32'h00, 32'h04, 32'h0,        4'h0, 2'b01, 2'd1, 1'b1};
    tbl[7]  = '{1'b0, 2'b11, 2'b00, 32'h00, 32'h04, 32'h0,        4'h0, 2'b01, 2'd1, 1'b1};
    tbl[8]  = '{1'b0, 2'b11, 2'b00, 32'h00, 32'h04, 32'h0,        4'h0, 2'b01, 2'd1, 1'b1};
    tbl[9]  = '{1'b0, 2'b11, 2'b00, 32'h00, 32'h04, 32'h0,        4'h0, 2'b10, 2'd2, 1'b1};
    tbl[10] = '{1'b0, 2'b11, 2'b00, 32'h08, 32'h04, 32'h0,        4'h0, 2'b01, 2'd1, 1'b1};
    tbl[11] = '{1'b0, 2'b10, 2'b10, 32'h00, 32'h20, 32'h00000012, 4'h1, 2'b11, 2'd2, 1'b1};
    tbl[12] = '{1'b0, 2'b01, 2'b00, 32'h20, 32'h00, 32'h0,        4'h0, 2'b01, 2'd1, 1'b1};
    tbl[13] = '{1'b0, 2'b00, 2'b00, 32'h00, 32'h00, 32'h0,        4'h0, 2'b11, 2'd0, 1'b1};
    tbl[14] = '{1'b0, 2'b01, 2'b00, 32'h08, 32'h00, 32'h0,        4'h0, 2'b01, 2'd1, 1'b1};

    // reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_phase_run", 64'(io_phaseRun), 64'h0);
    check("rst_resp_valid", 64'(io_resp_valid), 64'h0);
    check("rst_we", 64'(w_we), 64'h0);
    check("rst_rd_address", 64'(io_mem_rdAddress), 64'h0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) apply(tbl[i]);

    // reset lands while the read issued by tbl[14] is awaiting its response
    io_loadDone  = 1'b0;
    io_req_valid = 2'b00;
    io_req_write = 2'b00;
    reset        = 1'b0;
    #1;
    check("midrst_resp_valid", 64'(io_resp_valid), 64'h0);
    check("midrst_phase_run", 64'(io_phaseRun), 64'h0);
    check("midrst_rd_address", 64'(io_mem_rdAddress), 64'h0);
    exp_q.delete();
    exp_last_rd = 32'h0;
    @(posedge clock);
    #1;
    reset = 1'b1;

    rv = '{1'b0, 2'b11, 2'b10, 32'h00, 32'h30, 32'h00005555, 4'h3, 2'b10, 2'd2, 1'b0};
    apply(rv);
    rv = '{1'b0, 2'b01, 2'b00, 32'h30, 32'h00, 32'h0, 4'h0, 2'b10, 2'd0, 1'b0};
    apply(rv);
    rv = '{1'b0, 2'b10, 2'b00, 32'h00, 32'h30, 32'h0, 4'h0, 2'b10, 2'd2, 1'b0};
    apply(rv);
    rv = '{1'b0, 2'b00, 2'b00, 32'h00, 32'h00, 32'h0, 4'h0, 2'b10, 2'd0, 1'b0};
    apply(rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
